// File: rtl/apb_uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, frame
// width encoding and small combinational helpers used by the RX engine.
package apb_uart_pkg;

    // Receiver FSM states, kept as plain constants for legacy tools.
    typedef logic [2:0] rx_state_e;
    localparam rx_state_e RX_IDLE      = 3'd0;
    localparam rx_state_e RX_START     = 3'd1;
    localparam rx_state_e RX_DATA      = 3'd2;
    localparam rx_state_e RX_PARITY    = 3'd3;
    localparam rx_state_e RX_STOP      = 3'd4;
    localparam rx_state_e RX_WAIT_IDLE = 3'd5;

    // Parity selection; the reserved code behaves as no parity.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_e;

    // Frame width selection.
    typedef enum logic [1:0] {
        DATA_BITS_5 = 2'b00,
        DATA_BITS_6 = 2'b01,
        DATA_BITS_7 = 2'b10,
        DATA_BITS_8 = 2'b11
    } data_bits_e;

    // Index of the last data bit for a given width code (4..7).
    function automatic logic [2:0] last_data_index(input logic [1:0] code);
        return 3'd4 + {1'b0, code};
    endfunction

    // Two-of-three vote used to reject single-sample glitches.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when the parity mode carries a parity bit on the line.
    function automatic logic parity_enabled(input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return 1'b1;
            PAR_ODD:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle strobe every max(div_i,1) clocks.
// clear_i restarts the period so the next tick lands a full period later.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 clear_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] last_s;
    logic                 tick_q, tick_d;

    // Next-state of the period counter; 0 and 1 both mean a tick every cycle.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (div_i < DIV_WIDTH'(2)) begin
            last_s = '0;
        end else begin
            last_s = div_i - DIV_WIDTH'(1);
        end
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q >= last_s) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    // Period counter and registered tick strobe.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes the line, oversamples each bit with a
// majority vote, assembles the frame and presents it on a valid/ready port.
module uart_rx_engine
    import apb_uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 en_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic [1:0]           data_bits_i,
    input  logic [1:0]           parity_mode_i,
    input  logic                 stop_bits_i,
    output logic [7:0]           data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    // Line synchronizer and edge history (idle-high reset values).
    logic sync1_q, sync2_q, prev_q;
    logic rx_s, start_edge_s, tick_s, baud_clr_s, maj_s, mid_s, end_s;

    // Frame assembly state.
    rx_state_e     state_q, state_d;
    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic [1:0]    smp_q, smp_d;
    logic          bit_val_q, bit_val_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_acc_q, par_acc_d;
    logic          zero_q, zero_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    cfg_bits_q, cfg_bits_d;
    logic [1:0]    cfg_par_q, cfg_par_d;
    logic          cfg_stop_q, cfg_stop_d;
    logic          frame_done_s, ferr_now_s, brk_now_s;

    // Output holding register.
    logic [7:0] data_q, data_d;
    logic       perr_out_q, perr_out_d;
    logic       ferr_out_q, ferr_out_d;
    logic       brk_out_q, brk_out_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;

    assign rx_s         = sync2_q;
    assign start_edge_s = prev_q & ~rx_s;
    assign maj_s        = majority3(smp_q[0], smp_q[1], rx_s);
    assign mid_s        = tick_s && (smp_cnt_q == S_C);
    assign end_s        = tick_s && (smp_cnt_q == S_LAST);
    assign ferr_now_s   = ferr_q | ~maj_s;
    assign brk_now_s    = (bit_cnt_q == 3'd0) ? (zero_q & ~maj_s) : zero_q;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clear_i (baud_clr_s),
        .div_i   (clk_div_i),
        .tick_o  (tick_s)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver FSM: sampling, bit decisions and frame completion.
    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        smp_d        = smp_q;
        bit_val_d    = bit_val_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_acc_d    = par_acc_q;
        zero_d       = zero_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        cfg_bits_d   = cfg_bits_q;
        cfg_par_d    = cfg_par_q;
        cfg_stop_d   = cfg_stop_q;
        frame_done_s = 1'b0;
        baud_clr_s   = 1'b0;

        // Position within the current bit and the three vote samples.
        if (tick_s && (state_q != RX_IDLE) && (state_q != RX_WAIT_IDLE)) begin
            if (smp_cnt_q == S_LAST) begin
                smp_cnt_d = '0;
            end else begin
                smp_cnt_d = smp_cnt_q + SW'(1);
            end
            if (smp_cnt_q == S_A) begin
                smp_d[0] = rx_s;
            end else if (smp_cnt_q == S_B) begin
                smp_d[1] = rx_s;
            end else if (smp_cnt_q == S_C) begin
                bit_val_d = maj_s;
            end else begin
                smp_d = smp_q;
            end
        end else begin
            smp_cnt_d = smp_cnt_q;
        end

        case (state_q)
            RX_IDLE: begin
                if (start_edge_s) begin
                    state_d    = RX_START;
                    baud_clr_s = 1'b1;
                    smp_cnt_d  = '0;
                    bit_cnt_d  = 3'd0;
                    shreg_d    = 8'h00;
                    par_acc_d  = 1'b0;
                    zero_d     = 1'b1;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    cfg_bits_d = data_bits_i;
                    cfg_par_d  = parity_mode_i;
                    cfg_stop_d = stop_bits_i;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                // A high majority in the start bit means the edge was noise.
                if (mid_s && maj_s) begin
                    state_d = RX_IDLE;
                end else if (end_s) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (end_s) begin
                    shreg_d[bit_cnt_q] = bit_val_q;
                    par_acc_d          = par_acc_q ^ bit_val_q;
                    zero_d             = zero_q & ~bit_val_q;
                    if (bit_cnt_q == last_data_index(cfg_bits_q)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = parity_enabled(cfg_par_q) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (end_s) begin
                    // Even: data^parity must be 0; odd: it must be 1.
                    if (cfg_par_q == PAR_ODD) begin
                        perr_d = ~(par_acc_q ^ bit_val_q);
                    end else begin
                        perr_d = par_acc_q ^ bit_val_q;
                    end
                    zero_d    = zero_q & ~bit_val_q;
                    bit_cnt_d = 3'd0;
                    state_d   = RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                // The frame closes mid-way through the last stop bit so a
                // back-to-back start edge is never missed.
                if (mid_s) begin
                    ferr_d = ferr_now_s;
                    zero_d = brk_now_s;
                    if (!cfg_stop_q || (bit_cnt_q == 3'd1)) begin
                        frame_done_s = 1'b1;
                        state_d      = ferr_now_s ? RX_WAIT_IDLE : RX_IDLE;
                    end else begin
                        state_d = RX_STOP;
                    end
                end else if (end_s) begin
                    bit_cnt_d = 3'd1;
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Disabling the receiver drops any frame in progress.
        if (!en_i) begin
            state_d      = RX_IDLE;
            frame_done_s = 1'b0;
            baud_clr_s   = 1'b0;
        end else begin
            frame_done_s = frame_done_s;
        end
    end

    // Receiver FSM and frame assembly registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= RX_IDLE;
            smp_cnt_q  <= '0;
            smp_q      <= 2'b11;
            bit_val_q  <= 1'b1;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            par_acc_q  <= 1'b0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            cfg_bits_q <= 2'b11;
            cfg_par_q  <= 2'b00;
            cfg_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            smp_q      <= smp_d;
            bit_val_q  <= bit_val_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_acc_q  <= par_acc_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            cfg_bits_q <= cfg_bits_d;
            cfg_par_q  <= cfg_par_d;
            cfg_stop_q <= cfg_stop_d;
        end
    end

    // Output register: load when empty or being drained, otherwise flag overrun.
    always_comb begin
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_out_d  = brk_out_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        if (frame_done_s) begin
            if (!valid_q || ready_i) begin
                data_d     = shreg_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_now_s;
                brk_out_d  = brk_now_s;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output holding register and overrun pulse.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q     <= 8'h00;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_out_q  <= brk_out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign break_o      = brk_out_q;
    assign valid_o      = valid_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: serial frames are generated
// cycle by cycle and accepted frames are compared with a frame-level model.
module tb_uart_rx_engine;

    localparam int OS = 16;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        en_i;
    logic        rx_i;
    logic [15:0] clk_div_i;
    logic [1:0]  data_bits_i;
    logic [1:0]  parity_mode_i;
    logic        stop_bits_i;
    logic [7:0]  data_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        break_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int ov_cnt = 0;
    int ov_cyc = 0;
    int start_cyc = 0;
    logic [10:0] got_q[$];

    uart_rx_engine #(.OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .en_i          (en_i),
        .rx_i          (rx_i),
        .clk_div_i     (clk_div_i),
        .data_bits_i   (data_bits_i),
        .parity_mode_i (parity_mode_i),
        .stop_bits_i   (stop_bits_i),
        .data_o        (data_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .break_o       (break_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .overrun_o     (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observe outputs between edges: record handshakes, valid cycles, overruns.
    always begin
        @(negedge clk_i);
        #1;
        if (valid_o) vcnt++;
        if (valid_o && ready_i) got_q.push_back({data_o, parity_err_o, frame_err_o, break_o});
        if (overrun_o) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Frame-level reference: {data, parity_err, frame_err, break}.
    function automatic logic [10:0] model(input logic [7:0] val, input logic [1:0] code,
                                          input logic [1:0] pm, input logic flip,
                                          input logic s1, input logic s2, input logic two);
        int n;
        logic [7:0] d;
        logic pen, pbit, x, perr, ferr, brk;
        n = 5 + int'(code);
        d = 8'h00;
        for (int i = 0; i < n; i++) d[i] = val[i];
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pbit = (^d) ^ (pm == 2'b10) ^ flip;
        x    = (^d) ^ pbit;
        perr = pen && ((pm == 2'b01) ? (x == 1'b1) : (x == 1'b0));
        ferr = !s1 || (two && !s2);
        brk  = (d == 8'h00) && (!pen || !pbit) && !s1;
        return {d, perr, ferr, brk};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drive one frame on rx_i, one line value per clock.
    task automatic send_frame(input logic [7:0] val, input logic [1:0] code, input logic [1:0] pm,
                              input logic flip, input logic s1, input logic s2, input logic two,
                              input int div, input int g_start, input int g_len, input logic scramble);
        logic fb[0:12];
        logic [7:0] d;
        int n, nb, bc;
        logic glitch;
        n  = 5 + int'(code);
        bc = ((div < 2) ? 1 : div) * OS;
        clk_div_i     = div[15:0];
        data_bits_i   = code;
        parity_mode_i = pm;
        stop_bits_i   = two;
        d = 8'h00;
        for (int i = 0; i < n; i++) d[i] = val[i];
        nb = 0;
        fb[nb] = 1'b0; nb++;
        for (int i = 0; i < n; i++) begin fb[nb] = d[i]; nb++; end
        if (pm == 2'b01 || pm == 2'b10) begin
            fb[nb] = (^d) ^ (pm == 2'b10) ^ flip; nb++;
        end
        fb[nb] = s1; nb++;
        if (two) begin fb[nb] = s2; nb++; end
        for (int c = 0; c < nb * bc; c++) begin
            @(negedge clk_i);
            if (c == 0) start_cyc = cyc;
            if (scramble && c == bc) begin
                data_bits_i   = 2'($urandom_range(0, 3));
                parity_mode_i = 2'($urandom_range(0, 3));
                stop_bits_i   = 1'($urandom_range(0, 1));
            end
            glitch = (g_start >= 0) && (c >= g_start) && (c < g_start + g_len);
            rx_i = fb[c / bc] ^ glitch;
        end
        @(negedge clk_i);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        idle(3);
        checks++;
        if ({valid_o, data_o, parity_err_o, frame_err_o, break_o, overrun_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_during: got %h expected 0", {valid_o, data_o, parity_err_o, frame_err_o, break_o, overrun_o});
        end
        arst_ni = 1'b1;
        idle(20);
        checks++;
        if ({valid_o, data_o, parity_err_o, frame_err_o, break_o, overrun_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_after: got %h expected 0", {valid_o, data_o, parity_err_o, frame_err_o, break_o, overrun_o});
        end
    endtask

    task automatic test_basic();
        int v0;
        got_q.delete();
        v0 = vcnt;
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1, 0, 1'b0);
        idle(3 * 64);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d frames expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'hA5, 3'b000}) begin
                errors++;
                $display("FAIL basic_frame: got %h expected %h", got_q[0], {8'hA5, 3'b000});
            end
        end
        checks++;
        if (vcnt - v0 != 1) begin
            errors++;
            $display("FAIL basic_valid_cycles: got %0d expected 1", vcnt - v0);
        end
        checks++;
        if ({valid_o, data_o} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL basic_after: got %h expected %h", {valid_o, data_o}, {1'b0, 8'hA5});
        end
    endtask

    task automatic test_parity();
        got_q.delete();
        send_frame(8'h41, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 4, -1, 0, 1'b0);
        idle(3 * 64);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL parity_count: got %0d frames expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'h41, 3'b100}) begin
                errors++;
                $display("FAIL parity_frame: got %h expected %h", got_q[0], {8'h41, 3'b100});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] val;
        logic [1:0] code, pm;
        logic flip, s1, s2, two;
        int div, bc;
        logic [10:0] exp;
        for (int it = 0; it < 12; it++) begin
            val  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            code = 2'($urandom_range(0, 3));
            pm   = 2'($urandom_range(0, 3));
            flip = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            two  = 1'($urandom_range(0, 1));
            div  = $urandom_range(0, 5);
            bc   = ((div < 2) ? 1 : div) * OS;
            exp  = model(val, code, pm, flip, s1, s2, two);
            got_q.delete();
            send_frame(val, code, pm, flip, s1, s2, two, div, -1, 0, 1'b1);
            idle(3 * bc);
            checks++;
            if (got_q.size() != 1) begin
                errors++;
                $display("FAIL random_count[%0d]: got %0d frames expected 1", it, got_q.size());
            end else begin
                checks++;
                if (got_q[0] !== exp) begin
                    errors++;
                    $display("FAIL random_frame[%0d]: got %h expected %h (val %h code %0d pm %0d)", it, got_q[0], exp, val, code, pm);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int v0;
        got_q.delete();
        v0 = vcnt;
        clk_div_i = 16'd4;
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        idle(3 * 64);
        checks++;
        if (got_q.size() != 0 || vcnt != v0) begin
            errors++;
            $display("FAIL glitch_false_start: got %0d frames expected 0", got_q.size());
        end
        send_frame(8'h96, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4, 4 * 64 + 37, 4, 1'b0);
        idle(3 * 64);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_count: got %0d frames expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'h96, 3'b000}) begin
                errors++;
                $display("FAIL glitch_frame: got %h expected %h", got_q[0], {8'h96, 3'b000});
            end
        end
    endtask

    task automatic test_break();
        got_q.delete();
        clk_div_i = 16'd2; data_bits_i = 2'b11; parity_mode_i = 2'b00; stop_bits_i = 1'b0;
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (12 * 32) @(negedge clk_i);
        rx_i = 1'b1;
        idle(3 * 32);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL break_count: got %0d frames expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'h00, 3'b011}) begin
                errors++;
                $display("FAIL break_frame: got %h expected %h", got_q[0], {8'h00, 3'b011});
            end
        end
        got_q.delete();
        send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2, -1, 0, 1'b0);
        idle(3 * 32);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {8'h3C, 3'b000}) begin
            errors++;
            $display("FAIL break_recover: got %0d frames, first %h expected %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, {8'h3C, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        int ov0, s2, x2;
        got_q.delete();
        ready_i = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1, 0, 1'b0);
        idle(32);
        send_frame(8'h22, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1, 0, 1'b0);
        s2 = start_cyc;
        idle(32);
        x2 = ov_cyc;
        checks++;
        if ({valid_o, data_o} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL overrun_hold: got %h expected %h", {valid_o, data_o}, {1'b1, 8'h11});
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - ov0);
        end
        fork
            send_frame(8'h33, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1, 0, 1'b0);
            begin
                int s3, x3;
                @(negedge clk_i);
                s3 = cyc;
                x3 = s3 + (x2 - s2);
                for (int k = 0; k < 2000 && cyc < x3 - 1; k++) @(negedge clk_i);
                ready_i = 1'b1;
                @(negedge clk_i);
                ready_i = 1'b0;
            end
        join
        idle(32);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {8'h11, 3'b000}) begin
            errors++;
            $display("FAIL handshake_first: got %0d frames, first %h expected %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, {8'h11, 3'b000});
        end
        checks++;
        if ({valid_o, data_o} !== {1'b1, 8'h33}) begin
            errors++;
            $display("FAIL handshake_load: got %h expected %h", {valid_o, data_o}, {1'b1, 8'h33});
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL handshake_no_overrun: got %0d expected 1", ov_cnt - ov0);
        end
        ready_i = 1'b1;
        idle(4);
        checks++;
        if (got_q.size() != 2 || got_q[got_q.size() - 1] !== {8'h33, 3'b000} || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL handshake_drain: got %0d frames, valid %b expected 2 frames ending %h", got_q.size(), valid_o, {8'h33, 3'b000});
        end
    endtask

    task automatic test_enable_reset();
        int v0;
        got_q.delete();
        ready_i = 1'b1;
        v0 = vcnt;
        fork
            send_frame(8'hF0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2, -1, 0, 1'b0);
            begin
                repeat (6 * 32 + 1) @(negedge clk_i);
                en_i = 1'b0;
                repeat (48) @(negedge clk_i);
                en_i = 1'b1;
            end
        join
        idle(96);
        checks++;
        if (got_q.size() != 0 || vcnt != v0) begin
            errors++;
            $display("FAIL enable_drop: got %0d frames expected 0", got_q.size());
        end
        fork
            send_frame(8'hF0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2, -1, 0, 1'b0);
            begin
                repeat (6 * 32 + 1) @(negedge clk_i);
                arst_ni = 1'b0;
                repeat (5) @(negedge clk_i);
                arst_ni = 1'b1;
            end
        join
        idle(96);
        checks++;
        if (got_q.size() != 0 || vcnt != v0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: got %0d frames data %h expected 0 frames data 00", got_q.size(), data_o);
        end
        send_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2, -1, 0, 1'b0);
        idle(96);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {8'h5A, 3'b000}) begin
            errors++;
            $display("FAIL clean_after_abort: got %0d frames, first %h expected %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, {8'h5A, 3'b000});
        end
    endtask

    initial begin
        rx_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; clk_div_i = 16'd4;
        data_bits_i = 2'b11; parity_mode_i = 2'b00; stop_bits_i = 1'b0;
        arst_ni = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_random();
        test_glitch();
        test_break();
        test_back_to_back();
        test_enable_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
